// File: rtl/u_pe_feeder.sv
// u_pe_feeder: streams one KSIZE x KSIZE window into a four-row PE column, then injects psums.
// Optional build macro PE_FEED_ZERO_SKIP_EN: zero-weight beats are consumed but not flagged valid.

module u_pe_feeder_lane #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk_cal,
  input  logic                 rst_cal,
  input  logic                 ld_map,
  input  logic [DATA_SIZE-1:0] map_d,
  input  logic                 ld_din,
  input  logic [DATA_SIZE-1:0] din_d,
  output logic [DATA_SIZE-1:0] map_q,
  output logic [DATA_SIZE-1:0] din_q
);
  always_ff @(posedge clk_cal) begin
    if (!rst_cal) begin
      map_q <= '0;
      din_q <= '0;
    end else begin
      if (ld_map) map_q <= map_d;
      if (ld_din) din_q <= din_d;
    end
  end
endmodule

module u_pe_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int KSIZE     = 5,
  parameter int CNT_W     = 5
) (
  input  logic                   clk_cal,
  input  logic                   rst_cal,
  input  logic                   start,
  input  logic [DATA_SIZE-1:0]   bias_in,
  input  logic [4*DATA_SIZE-1:0] psum_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_SIZE-1:0]   w_in,
  input  logic [4*DATA_SIZE-1:0] m_in,
  output logic [DATA_SIZE-1:0]   IWeight,
  output logic                   IweightVld,
  output logic [DATA_SIZE-1:0]   IMap_0,
  output logic [DATA_SIZE-1:0]   IMap_1,
  output logic [DATA_SIZE-1:0]   IMap_2,
  output logic [DATA_SIZE-1:0]   IMap_3,
  output logic                   ImapVld_0,
  output logic                   ImapVld_1,
  output logic                   ImapVld_2,
  output logic                   ImapVld_3,
  output logic [DATA_SIZE-1:0]   bias,
  output logic [DATA_SIZE-1:0]   din_0,
  output logic [DATA_SIZE-1:0]   din_1,
  output logic [DATA_SIZE-1:0]   din_2,
  output logic [DATA_SIZE-1:0]   din_3,
  output logic                   dinVld,
  output logic                   busy,
  output logic                   done
);
  localparam int NUM_LANES = 4;
  localparam int STAGES    = 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KSIZE*KSIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_PSUM, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_SIZE-1:0]                w;
    logic [NUM_LANES-1:0][DATA_SIZE-1:0] map;
  } beat_t;

  state_t                              state, state_nxt;
  logic [CNT_W-1:0]                    cnt;
  logic                                accept, fwd, start_acc;
  beat_t                               beat_d;
  logic [NUM_LANES-1:0][DATA_SIZE-1:0] psum_v, map_q, din_q;
  logic [DATA_SIZE-1:0]                w_q, bias_q;
  logic [STAGES:1]                     vld_q;
  logic [STAGES:0]                     vld_pipe;

  assign accept    = in_valid && in_ready;
  assign start_acc = (state == S_IDLE) && start;
  assign psum_v    = psum_in;

  always_comb begin
    beat_d     = '0;
    beat_d.w   = w_in;
    beat_d.map = m_in;
  end

`ifdef PE_FEED_ZERO_SKIP_EN
  // Zero-weight beats still count toward the window but never reach the PEs.
  assign fwd = accept && (w_in != '0);
`else
  assign fwd = accept;
`endif

  always_comb begin
    vld_pipe             = '0;
    vld_pipe[0]          = fwd;
    vld_pipe[STAGES:1]   = vld_q;
  end

  always_ff @(posedge clk_cal) begin
    if (!rst_cal) begin
      state <= S_IDLE;
      cnt   <= '0;
      vld_q <= '0;
    end else begin
      state <= state_nxt;
      vld_q <= vld_pipe[STAGES-1:0];
      if (accept) cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (accept && (cnt == LAST_BEAT)) state_nxt = S_FLUSH;
      S_FLUSH:  state_nxt = S_PSUM;
      S_PSUM:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cal) begin
    if (!rst_cal) begin
      w_q    <= '0;
      bias_q <= '0;
    end else begin
      if (fwd)       w_q    <= beat_d.w;
      if (start_acc) bias_q <= bias_in;
    end
  end

  for (genvar r = 0; r < NUM_LANES; r++) begin : g_lane
    u_pe_feeder_lane #(.DATA_SIZE(DATA_SIZE)) u_lane (
      .clk_cal (clk_cal),
      .rst_cal (rst_cal),
      .ld_map  (fwd),
      .map_d   (beat_d.map[r]),
      .ld_din  (start_acc),
      .din_d   (psum_v[r]),
      .map_q   (map_q[r]),
      .din_q   (din_q[r])
    );
  end

  assign in_ready   = (state == S_STREAM);
  assign dinVld     = (state == S_PSUM);
  assign done       = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign IWeight    = w_q;
  assign IweightVld = vld_pipe[STAGES];
  assign ImapVld_0  = vld_pipe[STAGES];
  assign ImapVld_1  = vld_pipe[STAGES];
  assign ImapVld_2  = vld_pipe[STAGES];
  assign ImapVld_3  = vld_pipe[STAGES];
  assign IMap_0     = map_q[0];
  assign IMap_1     = map_q[1];
  assign IMap_2     = map_q[2];
  assign IMap_3     = map_q[3];
  assign bias       = bias_q;
  assign din_0      = din_q[0];
  assign din_1      = din_q[1];
  assign din_2      = din_q[2];
  assign din_3      = din_q[3];
endmodule

// File: tb/tb_u_pe_feeder.sv
// Bench for u_pe_feeder: window-level reference model checked every cycle, plus directed timing checks.
module tb_u_pe_feeder;
  localparam int BEATS = 25;
`ifdef PE_FEED_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk_cal, rst_cal, start, in_valid, in_ready;
  logic [7:0]  bias_in, w_in, IWeight, IMap_0, IMap_1, IMap_2, IMap_3, bias;
  logic [7:0]  din_0, din_1, din_2, din_3;
  logic [31:0] psum_in, m_in;
  logic        IweightVld, ImapVld_0, ImapVld_1, ImapVld_2, ImapVld_3, dinVld, busy, done;

  u_pe_feeder dut (
    .clk_cal(clk_cal), .rst_cal(rst_cal), .start(start), .bias_in(bias_in), .psum_in(psum_in),
    .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .m_in(m_in),
    .IWeight(IWeight), .IweightVld(IweightVld),
    .IMap_0(IMap_0), .IMap_1(IMap_1), .IMap_2(IMap_2), .IMap_3(IMap_3),
    .ImapVld_0(ImapVld_0), .ImapVld_1(ImapVld_1), .ImapVld_2(ImapVld_2), .ImapVld_3(ImapVld_3),
    .bias(bias), .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .dinVld(dinVld), .busy(busy), .done(done)
  );

  initial clk_cal = 1'b0;
  always #5 clk_cal = ~clk_cal;

  int n_vec = 0, n_err = 0, cyc = 0;

  // Reference model: a window is "busy" from accepted start; beats counted until 25,
  // then three tail cycles (last valid, psum inject, done).
  bit          m_busy = 1'b0, armed = 1'b0, m_acc;
  int          m_beats = 0, m_tail = 0;
  bit          e_vld = 1'b0;
  logic [7:0]  e_w = '0, e_bias = '0;
  logic [31:0] e_map = '0, e_din = '0;

  function automatic bit m_ready();
    return m_busy && (m_beats < BEATS);
  endfunction

  initial forever begin
    @(posedge clk_cal);
    cyc++;
    if (!rst_cal) begin
      m_busy = 1'b0; m_beats = 0; m_tail = 0; e_vld = 1'b0;
      e_w = '0; e_bias = '0; e_map = '0; e_din = '0;
    end else begin
      m_acc = m_ready() && in_valid;
      e_vld = m_acc && (!ZS || (w_in != 8'd0));
      if (e_vld) begin e_w = w_in; e_map = m_in; end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_beats = 0; m_tail = 0; e_bias = bias_in; e_din = psum_in;
        end
      end else if (m_beats < BEATS) begin
        if (m_acc) begin
          m_beats++;
          if (m_beats == BEATS) m_tail = 1;
        end
      end else begin
        m_tail++;
        if (m_tail == 4) begin m_busy = 1'b0; m_tail = 0; end
      end
    end
    armed = 1'b1;
  end

  function automatic logic [88:0] act_vec();
    return {in_ready, IweightVld, ImapVld_3, ImapVld_2, ImapVld_1, ImapVld_0, IWeight,
            IMap_3, IMap_2, IMap_1, IMap_0, bias, din_3, din_2, din_1, din_0, dinVld, busy, done};
  endfunction

  function automatic logic [88:0] exp_vec();
    return {m_ready(), e_vld, {4{e_vld}}, e_w, e_map, e_bias, e_din,
            (m_tail == 2), m_busy, (m_tail == 3)};
  endfunction

  // Window statistics observed from the DUT, used by the literal checks.
  int vld_cnt, first_vld, first_w, last_vld, done_cyc, dinv_cnt, din_seen, bias_seen;
  int done_cnt = 0;
  int wq[$];
  bit busy_log [int];

  initial forever begin
    @(negedge clk_cal);
    if (armed) begin
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL cycle_vector cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (IweightVld) begin
        vld_cnt++;
        if (first_vld < 0) begin first_vld = cyc; first_w = int'(IWeight); end
        last_vld = cyc;
        wq.push_back(int'(IWeight));
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (dinVld) begin
        dinv_cnt++; din_seen = int'({din_3, din_2, din_1, din_0}); bias_seen = int'(bias);
      end
      busy_log[cyc] = busy;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    vld_cnt = 0; first_vld = -1; first_w = -1; last_vld = -1; done_cyc = -1;
    dinv_cnt = 0; din_seen = 0; bias_seen = 0;
    wq.delete();
  endtask

  // pat: 0 always valid, 1 toggling, 2 random; beat i carries w = i + wofs (0 on beats 3,7 if zmask)
  task automatic drive_beat(input int pat, input int wofs, input bit zmask, input int n);
    int i;
    i = m_beats;
    case (pat)
      0:       in_valid = 1'b1;
      1:       in_valid = (n % 2 == 0);
      default: in_valid = ($urandom_range(0, 2) != 0);
    endcase
    w_in = (zmask && (i == 3 || i == 7)) ? 8'd0 : 8'(i + wofs);
    m_in = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
  endtask

  task automatic run_window(input int pat, input int wofs, input bit zmask, input bit poke,
                            output int s_cyc);
    int n, d0;
    @(negedge clk_cal); #1;
    clear_stats();
    start = 1'b1; bias_in = 8'h05; psum_in = 32'h04030201; in_valid = 1'b0;
    s_cyc = cyc; d0 = done_cnt; n = 0;
    forever begin
      @(negedge clk_cal); #1;
      if (done_cnt != d0) break;
      if (n >= 400) begin
        n_vec++; n_err++;
        $display("FAIL window_timeout act=no_done exp=done");
        break;
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_beat(pat, wofs, zmask, n);
      n++;
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    int s, dc, d1, n;
    rst_cal = 1'b0; start = 1'b0; bias_in = '0; psum_in = '0; in_valid = 1'b0;
    w_in = '0; m_in = '0;
    clear_stats();
    repeat (3) @(negedge clk_cal);
    #1;
    chk("reset_all_zero", int'(act_vec() == '0), 1);
    rst_cal = 1'b1;

    // basic window: w=i, rows {i+3,i+2,i+1,i}
    run_window(0, 0, 1'b0, 1'b0, s);
    repeat (3) @(negedge clk_cal);
    #1;
    chk("first_vld_latency", first_vld - s, ZS ? 3 : 2);
    chk("first_weight", first_w, ZS ? 1 : 0);
    chk("vld_count", vld_cnt, ZS ? 24 : 25);
    chk("vld_consecutive", last_vld - first_vld + 1, ZS ? 24 : 25);
    chk("done_after_last_vld", done_cyc - last_vld, 2);
    chk("done_from_start", done_cyc - s, 28);
    chk("din_values", din_seen, 32'h04030201);
    chk("bias_value", bias_seen, 5);
    chk("dinvld_pulses", dinv_cnt, 1);

    // toggling in_valid
    run_window(1, 1, 1'b0, 1'b0, s);
    repeat (2) @(negedge clk_cal);
    #1;
    chk("toggle_vld_count", vld_cnt, 25);
    chk("toggle_done_after_last", done_cyc - last_vld, 2);

    // zero weights on beats 3 and 7
    run_window(0, 1, 1'b1, 1'b0, s);
    repeat (2) @(negedge clk_cal);
    #1;
    chk("zero_vld_count", vld_cnt, ZS ? 23 : 25);
    chk("zero_wq3", wq.size() > 7 ? wq[3] : -1, ZS ? 5 : 0);
    chk("zero_wq7", wq.size() > 7 ? wq[7] : -1, ZS ? 10 : 0);
    chk("zero_done_from_start", done_cyc - s, 28);

    // start poked during the window
    dc = done_cnt;
    run_window(0, 1, 1'b0, 1'b1, s);
    repeat (6) @(negedge clk_cal);
    #1;
    chk("poke_one_done", done_cnt - dc, 1);
    chk("poke_vld_count", vld_cnt, 25);

    // reset after 10 beats
    clear_stats();
    start = 1'b1; bias_in = 8'h05; psum_in = 32'h04030201;
    n = 0;
    forever begin
      @(negedge clk_cal); #1;
      if (m_beats == 10 || n >= 100) break;
      start = 1'b0;
      drive_beat(0, 1, 1'b0, n);
      n++;
    end
    chk("beats_before_reset", m_beats, 10);
    dc = done_cnt;
    rst_cal = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk_cal); #1;
    chk("midreset_all_zero", int'(act_vec() == '0), 1);
    chk("midreset_busy", int'(busy), 0);
    rst_cal = 1'b1;
    repeat (4) @(negedge clk_cal);
    #1;
    chk("midreset_no_done", done_cnt - dc, 0);
    run_window(0, 1, 1'b0, 1'b0, s);
    repeat (2) @(negedge clk_cal);
    #1;
    chk("post_reset_vld_count", vld_cnt, 25);
    chk("post_reset_done_timing", done_cyc - s, 28);

    // start held high across two windows
    clear_stats();
    dc = done_cnt; d1 = -1; n = 0;
    start = 1'b1; bias_in = 8'h05; psum_in = 32'h04030201;
    forever begin
      @(negedge clk_cal); #1;
      if (d1 < 0 && done_cnt - dc == 1) d1 = done_cyc;
      if (done_cnt - dc >= 2) break;
      if (n >= 400) begin
        n_vec++; n_err++;
        $display("FAIL held_timeout act=%0d exp=2", done_cnt - dc);
        break;
      end
      drive_beat(0, 1, 1'b0, n);
      n++;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("held_idle_gap", int'(busy_log[d1 + 1]), 0);
    chk("held_busy_again", int'(busy_log[d1 + 2]), 1);
    chk("held_second_done", done_cyc - d1, 29);

    // random traffic, occasional resets
    repeat (3000) begin
      @(negedge clk_cal); #1;
      rst_cal  = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      w_in     = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      m_in     = $urandom;
      bias_in  = 8'($urandom);
      psum_in  = $urandom;
    end
    @(negedge clk_cal); #1;
    rst_cal = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (40) @(negedge clk_cal);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
